// File: rtl/rr_arb_encoder_if.sv
// rr_arb_encoder_if: request/grant bundle between requesters, arbiter and downstream consumer
interface rr_arb_encoder_if #(parameter int N = 4);
    localparam int IDX_W = $clog2(N);
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_onehot;
    logic [IDX_W-1:0] out_idx;
    modport master (input req_valid, out_ready, output req_ready, out_valid, out_onehot, out_idx);
    modport slave (output req_valid, out_ready, input req_ready, out_valid, out_onehot, out_idx);
endinterface

// File: rtl/rr_arb_encoder.sv
// rr_arb_encoder: N-way fixed-priority/round-robin arbiter with registered one-hot and index grant
module rr_arb_encoder #(
    parameter int N    = 4,
    parameter int MODE = 1
) (
    input logic clk,
    input logic resetn,
    rr_arb_encoder_if.master bus
);
    localparam int IDX_W = $clog2(N);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state, state_nx;
    logic [N-1:0]     onehot_q, onehot_nx, rot;
    logic [IDX_W-1:0] idx_q, idx_nx, ptr, ptr_nx, sel_ptr, base, pos, win_idx;
    logic [IDX_W:0]   sum;
    logic [2*N-1:0]   dbl;
    logic             hs, any, load;
    assign bus.out_valid  = (state == GRANT);
    assign bus.out_onehot = onehot_q;
    assign bus.out_idx    = idx_q;
    assign hs             = bus.out_valid & bus.out_ready;
    assign bus.req_ready  = onehot_q & {N{hs}};
    assign any            = |bus.req_valid;
    // on a handshake the just-served requester drops to lowest priority
    assign sel_ptr = hs ? ((idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1)) : ptr;
    assign base    = (MODE != 0) ? sel_ptr : '0;
    assign dbl     = {bus.req_valid, bus.req_valid} >> base;
    assign rot     = dbl[N-1:0];
    always_comb begin
        pos = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) pos = IDX_W'(i);
    end
    assign sum     = {1'b0, pos} + {1'b0, base};
    assign win_idx = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : sum[IDX_W-1:0];
    always_comb begin
        load      = (state == IDLE) | hs;
        state_nx  = load ? (any ? GRANT : IDLE) : state;
        onehot_nx = load ? (any ? N'(1) << win_idx : '0) : onehot_q;
        idx_nx    = load ? (any ? win_idx : '0) : idx_q;
        ptr_nx    = (MODE != 0 && hs) ? sel_ptr : ptr;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            onehot_q <= '0;
            idx_q    <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_nx;
            onehot_q <= onehot_nx;
            idx_q    <= idx_nx;
            ptr      <= ptr_nx;
        end
    end
endmodule
